// File: rtl/wb_ram_burst_if.sv
// rtl/wb_ram_burst_if.sv - Wishbone B4 bus bundle for the burst RAM slave
// Signal names keep the slave's point of view (_i into the RAM, _o out of it).
interface wb_ram_burst_if #(
   parameter int DW = 32
) ();
   logic [31:0]     wb_adr_i;
   logic [DW-1:0]   wb_dat_i;
   logic [DW/8-1:0] wb_sel_i;
   logic            wb_we_i;
   logic            wb_cyc_i;
   logic            wb_stb_i;
   logic [2:0]      wb_cti_i;
   logic [1:0]      wb_bte_i;
   logic            wb_ack_o;
   logic            wb_err_o;
   logic [DW-1:0]   wb_dat_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      input  wb_ack_o, wb_err_o, wb_dat_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
      output wb_ack_o, wb_err_o, wb_dat_o
   );
endinterface

// File: rtl/wb_ram_burst.sv
// rtl/wb_ram_burst.sv - Wishbone B4 RAM with wait states, CTI/BTE bursts, error response and sim MMIO hooks
// ack/err/dat are registered; the next beat is acked speculatively from the current beat's cti.
module wb_ram_burst #(
   parameter int          DW          = 32,
   parameter int          DEPTH       = 1024,
   parameter int          WAIT        = 0,
   parameter string       MEMFILE     = "",
   parameter logic [31:0] CONSOLE_ADR = 32'h1000_0000,
   parameter logic [31:0] PASS_ADR    = 32'h2000_0000,
   parameter logic [31:0] PASS_VAL    = 32'd123456789
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   wb_ram_burst_if.slave    wb,
   output logic             tests_passed
);
   localparam int SW = DW / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int SB = $clog2(SW);

   typedef enum logic [2:0] {S_IDLE, S_WAITST, S_RESP, S_BURST, S_GAP} state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [31:0]    adr_q, adr_d;
   logic           ack_q, ack_d;
   logic           err_q, err_d;
   logic [DW-1:0]  dat_q, dat_d;
   logic           pass_q;
   logic [DW-1:0]  mem [DEPTH/SW];

   logic        valid, burst_cti, wr_beat;
   logic [31:0] beat_adr;

   function automatic logic in_mem(input logic [31:0] a);
      return a < 32'(DEPTH);
   endfunction

   function automatic logic is_mapped(input logic [31:0] a);
      return in_mem(a) || (a == CONSOLE_ADR) || (a == PASS_ADR);
   endfunction

   // Wrap-N keeps the upper bits and rolls the low log2(N*SW) bits.
   function automatic logic [31:0] next_beat(input logic [31:0] a, input logic [1:0] bte);
      logic [31:0] mask;
      case (bte)
         2'b01:   mask = 32'(4 * SW - 1);
         2'b10:   mask = 32'(8 * SW - 1);
         2'b11:   mask = 32'(16 * SW - 1);
         default: mask = '0;
      endcase
      if (bte == 2'b00) return a + 32'(SW);
      return (a & ~mask) | ((a + 32'(SW)) & mask);
   endfunction

   assign valid     = wb.wb_cyc_i & wb.wb_stb_i;
   assign burst_cti = (wb.wb_cti_i == 3'b010);
   assign beat_adr  = next_beat(adr_q, wb.wb_bte_i);
   assign wr_beat   = ack_q & valid & wb.wb_we_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         pass_q  <= pass_q | (wr_beat && adr_q == PASS_ADR && wb.wb_dat_i[31:0] == PASS_VAL);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      case (state_q)
         S_IDLE: begin
            if (valid) begin
               if (WAIT == 0) begin
                  state_d = S_RESP;
                  adr_d   = wb.wb_adr_i;
               end else begin
                  state_d = S_WAITST;
                  cnt_d   = '0;
               end
            end
         end
         S_WAITST: begin
            if (!valid) begin
               state_d = S_IDLE;
            end else if ({28'd0, cnt_q} + 32'd1 >= 32'(WAIT)) begin
               state_d = S_RESP;
               adr_d   = wb.wb_adr_i;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP: begin
            if (valid && burst_cti && is_mapped(adr_q)) begin
               state_d = S_BURST;
               adr_d   = beat_adr;
            end else begin
               state_d = S_GAP;
            end
         end
         S_BURST: begin
            if (!valid) begin
               state_d = S_IDLE;
            end else if (!burst_cti) begin
               state_d = S_GAP;
            end else begin
               // A beat running off the end of memory is answered from RESP with err.
               adr_d   = beat_adr;
               state_d = in_mem(beat_adr) ? S_BURST : S_RESP;
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ack_d = 1'b0;
      err_d = 1'b0;
      dat_d = '0;
      if (state_d == S_RESP || state_d == S_BURST) begin
         ack_d = is_mapped(adr_d);
         err_d = !is_mapped(adr_d);
         if (in_mem(adr_d)) dat_d = mem[adr_d[AW-1:SB]];
      end
   end

   // Memory has no reset so its contents survive wb_rst_ni.
   always_ff @(posedge wb_clk_i) begin
      if (wr_beat && in_mem(adr_q)) begin
         for (int b = 0; b < SW; b++) begin
            if (wb.wb_sel_i[b]) mem[adr_q[AW-1:SB]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
         end
      end
      if (wr_beat && adr_q == CONSOLE_ADR) $write("%c", wb.wb_dat_i[7:0]);
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_dat_o = dat_q;
   assign tests_passed = pass_q;
endmodule

// File: tb/tb_wb_ram_burst.sv
// tb/tb_wb_ram_burst.sv - directed bench for wb_ram_burst with a memory/address model and per-cycle response checker
module tb_wb_ram_burst;
   localparam int          DW    = 32;
   localparam int          DEPTH = 1024;
   localparam int          WAIT  = 2;
   localparam logic [31:0] CON   = 32'h1000_0000;
   localparam logic [31:0] PASSA = 32'h2000_0000;
   localparam logic [31:0] PASSV = 32'd123456789;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tests_passed;

   wb_ram_burst_if #(.DW(DW)) bus ();

   wb_ram_burst #(.DW(DW), .DEPTH(DEPTH), .WAIT(WAIT)) dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .wb           (bus.slave),
      .tests_passed (tests_passed)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt  = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      logic        err;
      logic        chk_dat;
      logic [31:0] dat;
   } exp_t;
   exp_t exp_q[$];

   logic [31:0] model_mem [DEPTH/4];
   logic        model_pass = 1'b0;
   bit          skip_cmp = 1'b0;

   logic [31:0] wr_data  [16];
   logic [31:0] rd_data  [16];
   logic        resp_err [16];
   int          resp_cyc [16];
   int          n_resp;
   int          first_lat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int k, input logic [1:0] bte);
      int span;
      span = (bte == 2'b00) ? 0 : (2 << bte) * 4;
      if (span == 0) return start + 32'(4 * k);
      return (start - (start % span)) + ((start + 32'(4 * k)) % span);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
      if (a < DEPTH) begin
         for (int b = 0; b < 4; b++) if (sel[b]) model_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
      end
      if (a == PASSA && d == PASSV) model_pass = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && !skip_cmp) begin
         chk("tests_passed", {31'd0, tests_passed}, {31'd0, model_pass});
         if (bus.wb_ack_o || bus.wb_err_o) begin
            chk("ack_err_exclusive", {31'd0, bus.wb_ack_o & bus.wb_err_o}, 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_response: ack=%b err=%b, expected no response", bus.wb_ack_o, bus.wb_err_o);
            end else begin
               e = exp_q.pop_front();
               chk("resp_is_err", {31'd0, bus.wb_err_o}, {31'd0, e.err});
               if (e.chk_dat) chk("resp_data", bus.wb_dat_o, e.dat);
            end
         end
      end
   end

   task automatic drive_idle();
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_cti_i = 3'b000;
      bus.wb_bte_i = 2'b00;
      bus.wb_sel_i = 4'h0;
      bus.wb_adr_i = 32'd0;
      bus.wb_dat_i = 32'd0;
   endtask

   task automatic xfer(input logic [31:0] start, input int n, input bit we, input logic [3:0] sel, input logic [1:0] bte);
      int   nexp, k, guard, c0;
      logic [31:0] a;
      bit   mapped, got;
      exp_t e;
      nexp = 0;
      for (int i = 0; i < n; i++) begin
         a = beat_addr(start, i, bte);
         mapped = (a < DEPTH) || (i == 0 && (a == CON || a == PASSA));
         e.err = !mapped;
         e.chk_dat = !we || !mapped;
         e.dat = (!we && a < DEPTH) ? model_mem[a[9:2]] : 32'd0;
         exp_q.push_back(e);
         nexp++;
         if (!mapped) break;
      end
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_sel_i = sel;
      bus.wb_bte_i = bte;
      bus.wb_adr_i = start;
      bus.wb_dat_i = wr_data[0];
      bus.wb_cti_i = (n == 1) ? 3'b000 : 3'b010;
      c0 = cyc_cnt;
      k = 0;
      guard = 0;
      while (k < nexp && guard < 64) begin
         @(negedge clk);
         guard++;
         got = bus.wb_ack_o || bus.wb_err_o;
         if (got) begin
            resp_cyc[k] = cyc_cnt;
            resp_err[k] = bus.wb_err_o;
            rd_data[k]  = bus.wb_dat_o;
         end
         @(posedge clk); #1;
         if (got) begin
            if (we && !resp_err[k]) model_write(beat_addr(start, k, bte), wr_data[k], sel);
            k++;
            if (k < nexp) begin
               bus.wb_adr_i = beat_addr(start, k, bte);
               bus.wb_dat_i = wr_data[k];
               bus.wb_cti_i = (k == n - 1) ? 3'b111 : 3'b010;
            end
         end
      end
      n_resp = k;
      first_lat = resp_cyc[0] - c0;
      if (k < nexp) begin
         n_checks++;
         n_fail++;
         $display("FAIL xfer_timeout: %0d of %0d responses at 0x%08h", k, nexp, start);
      end
      drive_idle();
   endtask

   task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
      wr_data[0] = d;
      xfer(a, 1, 1'b1, sel, 2'b00);
   endtask

   task automatic rd1(input logic [31:0] a);
      xfer(a, 1, 1'b0, 4'hF, 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t4_exp [4];
      logic [31:0] t8_exp [4];
      int acks;
      bit got;
      for (int i = 0; i < DEPTH / 4; i++) model_mem[i] = 32'd0;
      drive_idle();

      // Reset state
      @(negedge clk);
      chk("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
      chk("rst_err", {31'd0, bus.wb_err_o}, 32'd0);
      chk("rst_dat", bus.wb_dat_o, 32'd0);
      chk("rst_tests_passed", {31'd0, tests_passed}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Classic write/read with WAIT=2
      wr1(32'h10, 32'hDEADBEEF, 4'hF);
      chk("t1_write_latency", first_lat, 32'd3);
      rd1(32'h10);
      chk("t1_read_data", rd_data[0], 32'hDEADBEEF);
      chk("t1_read_latency", first_lat, 32'd3);
      chk("t1_read_resp_count", n_resp, 32'd1);

      // Byte lanes
      wr1(32'h20, 32'h11223344, 4'hF);
      wr1(32'h20, 32'hAA000000, 4'b1000);
      rd1(32'h20);
      chk("t2_byte_lane", rd_data[0], 32'hAA223344);

      // Linear burst write then read
      for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
      xfer(32'h40, 4, 1'b1, 4'hF, 2'b00);
      chk("t3_wr_consecutive", resp_cyc[3] - resp_cyc[0], 32'd3);
      xfer(32'h40, 4, 1'b0, 4'hF, 2'b00);
      chk("t3_rd_consecutive", resp_cyc[3] - resp_cyc[0], 32'd3);
      for (int i = 0; i < 4; i++) chk($sformatf("t3_rd%0d", i), rd_data[i], 32'(i + 1));

      // Wrap4 read from 0x38
      wr1(32'h30, 32'hA30, 4'hF);
      wr1(32'h34, 32'hA34, 4'hF);
      wr1(32'h38, 32'hA38, 4'hF);
      wr1(32'h3C, 32'hA3C, 4'hF);
      t4_exp = '{32'hA38, 32'hA3C, 32'hA30, 32'hA34};
      xfer(32'h38, 4, 1'b0, 4'hF, 2'b01);
      for (int i = 0; i < 4; i++) chk($sformatf("t4_wrap%0d", i), rd_data[i], t4_exp[i]);
      chk("t4_consecutive", resp_cyc[3] - resp_cyc[0], 32'd3);

      // Unmapped accesses and a linear burst running past DEPTH
      wr1(32'h0, 32'h5555, 4'hF);
      rd1(32'd1024);
      chk("t5_rd_err", {31'd0, resp_err[0]}, 32'd1);
      chk("t5_rd_err_dat", rd_data[0], 32'd0);
      wr1(32'd1024, 32'hBAD, 4'hF);
      chk("t5_wr_err", {31'd0, resp_err[0]}, 32'd1);
      for (int i = 0; i < 4; i++) wr_data[i] = 32'hC0 + 32'(i);
      xfer(32'h3F8, 4, 1'b1, 4'hF, 2'b00);
      chk("t5_cross_resp_count", n_resp, 32'd3);
      chk("t5_cross_beat1_ack", {31'd0, resp_err[1]}, 32'd0);
      chk("t5_cross_beat2_err", {31'd0, resp_err[2]}, 32'd1);
      xfer(32'h3F8, 2, 1'b0, 4'hF, 2'b00);
      chk("t5_cross_rd0", rd_data[0], 32'hC0);
      chk("t5_cross_rd1", rd_data[1], 32'hC1);
      rd1(32'h0);
      chk("t5_mem0_unchanged", rd_data[0], 32'h5555);

      // cyc dropped during wait states
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
      bus.wb_sel_i = 4'hF; bus.wb_adr_i = 32'h10; bus.wb_dat_i = 32'h0BAD;
      @(posedge clk); #1;
      drive_idle();
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.wb_ack_o || bus.wb_err_o) acks++;
      end
      chk("t6_no_resp_after_abort", acks, 32'd0);
      rd1(32'h10);
      chk("t6_no_write_after_abort", rd_data[0], 32'hDEADBEEF);

      // MMIO console and pass flag
      wr1(CON, 32'h4F, 4'h1);
      wr1(CON, 32'h4B, 4'h1);
      wr1(CON, 32'h0A, 4'h1);
      rd1(CON);
      chk("t7_console_read_zero", rd_data[0], 32'd0);
      chk("t7_console_read_ack", {31'd0, resp_err[0]}, 32'd0);
      wr1(PASSA, 32'd5, 4'hF);
      chk("t7_wrong_pass_value", {31'd0, tests_passed}, 32'd0);
      wr1(PASSA, PASSV, 4'hF);
      repeat (3) @(negedge clk);
      chk("t7_tests_passed_set", {31'd0, tests_passed}, 32'd1);
      rd1(32'h10);
      chk("t7_tests_passed_sticky", {31'd0, tests_passed}, 32'd1);

      // Async reset in the middle of a write burst
      wr1(32'h88, 32'h88880088, 4'hF);
      wr1(32'h8C, 32'h8888008C, 4'hF);
      skip_cmp = 1'b1;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
      bus.wb_sel_i = 4'hF; bus.wb_bte_i = 2'b00; bus.wb_cti_i = 3'b010;
      bus.wb_adr_i = 32'h80; bus.wb_dat_i = 32'h77000000;
      acks = 0;
      for (int g = 0; g < 20 && acks < 2; g++) begin
         @(negedge clk);
         got = bus.wb_ack_o;
         @(posedge clk); #1;
         if (got) begin
            model_write(32'h80 + 32'(4 * acks), 32'h77000000 + 32'(acks), 4'hF);
            acks++;
            bus.wb_adr_i = 32'h80 + 32'(4 * acks);
            bus.wb_dat_i = 32'h77000000 + 32'(acks);
         end
      end
      chk("t8_two_beats_acked", acks, 32'd2);
      #1;
      chk("t8_spec_ack_before_reset", {31'd0, bus.wb_ack_o}, 32'd1);
      rst_n = 1'b0;
      model_pass = 1'b0;
      #1;
      chk("t8_rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
      chk("t8_rst_err", {31'd0, bus.wb_err_o}, 32'd0);
      chk("t8_rst_tests_passed", {31'd0, tests_passed}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      skip_cmp = 1'b0;
      t8_exp = '{32'h77000000, 32'h77000001, 32'h88880088, 32'h8888008C};
      xfer(32'h80, 4, 1'b0, 4'hF, 2'b00);
      for (int i = 0; i < 4; i++) chk($sformatf("t8_after_reset%0d", i), rd_data[i], t8_exp[i]);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
